// File: rtl/bp_be_dcache_port_arbiter_if.sv
// Request/response bundle between the mem pipe, the PTW, the D$ and the port arbiter.
// The arbiter connects through the slave modport; the requesters and the D$ side use the master modport.
interface bp_be_dcache_port_arbiter_if
  #(parameter int pkt_width_p  = 81
  , parameter int ptag_width_p = 28
  );

    logic                    flush;

    logic                    pipe_v;
    logic [pkt_width_p-1:0]  pipe_pkt;
    logic                    pipe_grant;
    logic [ptag_width_p-1:0] pipe_ptag;
    logic                    pipe_ptag_v;
    logic                    pipe_early_v;

    logic                    ptw_v;
    logic [pkt_width_p-1:0]  ptw_pkt;
    logic                    ptw_grant;
    logic [ptag_width_p-1:0] ptw_ptag;
    logic                    ptw_ptag_v;
    logic                    ptw_lock;
    logic                    ptw_early_v;

    logic                    dcache_ready;
    logic                    dcache_v;
    logic [pkt_width_p-1:0]  dcache_pkt;
    logic [ptag_width_p-1:0] dcache_ptag;
    logic                    dcache_ptag_v;
    logic                    dcache_early_v;

    logic                    busy;

    modport slave
      (input  flush
     , input  pipe_v, pipe_pkt, pipe_ptag, pipe_ptag_v
     , output pipe_grant, pipe_early_v
     , input  ptw_v, ptw_pkt, ptw_ptag, ptw_ptag_v, ptw_lock
     , output ptw_grant, ptw_early_v
     , input  dcache_ready, dcache_early_v
     , output dcache_v, dcache_pkt, dcache_ptag, dcache_ptag_v
     , output busy
     );

    modport master
      (output flush
     , output pipe_v, pipe_pkt, pipe_ptag, pipe_ptag_v
     , input  pipe_grant, pipe_early_v
     , output ptw_v, ptw_pkt, ptw_ptag, ptw_ptag_v, ptw_lock
     , input  ptw_grant, ptw_early_v
     , output dcache_ready, dcache_early_v
     , input  dcache_v, dcache_pkt, dcache_ptag, dcache_ptag_v
     , input  busy
     );

endinterface

// File: rtl/bp_be_dcache_port_arbiter.sv
// Shares the single D$ request port between the mem pipe and the PTW, tracking op ownership through mem1/mem2.
// Define BP_DCACHE_ARB_PERF_EN to add the grant and conflict performance counters.
module bp_be_dcache_port_arbiter
  #(parameter int page_offset_width_p = 12
  , parameter int dpath_width_p       = 64
  , parameter int ptag_width_p        = 28
  , parameter int opcode_width_p      = 5
  , parameter int starve_limit_p      = 8
  )
   (input  logic                           clk_i
  , input  logic                           reset_i
  , bp_be_dcache_port_arbiter_if.slave     arb_bus
`ifdef BP_DCACHE_ARB_PERF_EN
  , output logic [31:0]                    pipe_grants_o
  , output logic [31:0]                    ptw_grants_o
  , output logic [31:0]                    conflict_cycles_o
`endif
   );

    localparam int pkt_width_lp = opcode_width_p + page_offset_width_p + dpath_width_p;
    localparam logic [7:0] starve_limit_lp = 8'(starve_limit_p);

    logic [7:0] starve_cnt_r, starve_cnt_n;
    logic       mem1_v_r, mem1_own_r;
    logic       mem2_v_r, mem2_own_r;

    logic pipe_ok, starved;
    logic pipe_grant, ptw_grant;

    // A flushed pipe packet is never eligible, so a flush cannot leak a stale pipe op into mem1.
    assign pipe_ok = arb_bus.pipe_v & ~arb_bus.flush;
    assign starved = (starve_cnt_r == starve_limit_lp);

    always_comb begin
        pipe_grant = 1'b0;
        ptw_grant  = 1'b0;
        if (arb_bus.dcache_ready) begin
            if (arb_bus.ptw_lock) begin
                ptw_grant = arb_bus.ptw_v;
            end else if (starved & pipe_ok) begin
                pipe_grant = 1'b1;
            end else if (arb_bus.ptw_v) begin
                ptw_grant = 1'b1;
            end else begin
                pipe_grant = pipe_ok;
            end
        end
    end

    assign arb_bus.pipe_grant = pipe_grant;
    assign arb_bus.ptw_grant  = ptw_grant;
    assign arb_bus.dcache_v   = pipe_grant | ptw_grant;

    logic [pkt_width_lp-1:0] pipe_pkt_li, ptw_pkt_li;
    assign pipe_pkt_li        = arb_bus.pipe_pkt;
    assign ptw_pkt_li         = arb_bus.ptw_pkt;
    assign arb_bus.dcache_pkt = ptw_grant ? ptw_pkt_li : pipe_pkt_li;

    // Pipe losses only count while the pipe could have been served; a lock freezes the count.
    always_comb begin
        starve_cnt_n = starve_cnt_r;
        if (pipe_grant) begin
            starve_cnt_n = 8'd0;
        end else if (arb_bus.pipe_v & ~arb_bus.ptw_lock & arb_bus.dcache_ready
                     & ptw_grant & ~starved) begin
            starve_cnt_n = starve_cnt_r + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_cnt_r <= 8'd0;
            mem1_v_r     <= 1'b0;
            mem1_own_r   <= 1'b0;
            mem2_v_r     <= 1'b0;
            mem2_own_r   <= 1'b0;
        end else begin
            starve_cnt_r <= starve_cnt_n;
            mem1_v_r     <= pipe_grant | ptw_grant;
            mem1_own_r   <= ptw_grant;
            mem2_v_r     <= mem1_v_r & ~(arb_bus.flush & ~mem1_own_r);
            mem2_own_r   <= mem1_own_r;
        end
    end

    logic [ptag_width_p-1:0] pipe_ptag_li, ptw_ptag_li;
    assign pipe_ptag_li = arb_bus.pipe_ptag;
    assign ptw_ptag_li  = arb_bus.ptw_ptag;

    always_comb begin
        arb_bus.dcache_ptag   = '0;
        arb_bus.dcache_ptag_v = 1'b0;
        if (mem1_v_r) begin
            if (mem1_own_r) begin
                arb_bus.dcache_ptag   = ptw_ptag_li;
                arb_bus.dcache_ptag_v = arb_bus.ptw_ptag_v;
            end else begin
                arb_bus.dcache_ptag   = pipe_ptag_li;
                arb_bus.dcache_ptag_v = arb_bus.pipe_ptag_v & ~arb_bus.flush;
            end
        end
    end

    assign arb_bus.pipe_early_v = arb_bus.dcache_early_v & mem2_v_r & ~mem2_own_r;
    assign arb_bus.ptw_early_v  = arb_bus.dcache_early_v & mem2_v_r &  mem2_own_r;
    assign arb_bus.busy         = mem1_v_r | mem2_v_r;

`ifdef BP_DCACHE_ARB_PERF_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pipe_grants_o     <= 32'd0;
            ptw_grants_o      <= 32'd0;
            conflict_cycles_o <= 32'd0;
        end else begin
            pipe_grants_o     <= pipe_grants_o + 32'(pipe_grant);
            ptw_grants_o      <= ptw_grants_o + 32'(ptw_grant);
            conflict_cycles_o <= conflict_cycles_o
                                 + 32'(arb_bus.pipe_v & arb_bus.ptw_v & arb_bus.dcache_ready);
        end
    end
`endif

endmodule

// File: tb/tb_bp_be_dcache_port_arbiter.sv
// Directed and random checks of the D$ port arbiter against an op-list reference model.
module tb_bp_be_dcache_port_arbiter;

    localparam int POW   = 12;
    localparam int DPW   = 64;
    localparam int PTAGW = 28;
    localparam int OPW   = 5;
    localparam int LIMIT = 8;
    localparam int PKTW  = OPW + POW + DPW;

    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    bp_be_dcache_port_arbiter_if #(.pkt_width_p(PKTW), .ptag_width_p(PTAGW)) bus ();

`ifdef BP_DCACHE_ARB_PERF_EN
    logic [31:0] pipe_grants, ptw_grants, conflict_cycles;
`endif

    bp_be_dcache_port_arbiter
      #(.page_offset_width_p(POW)
      , .dpath_width_p(DPW)
      , .ptag_width_p(PTAGW)
      , .opcode_width_p(OPW)
      , .starve_limit_p(LIMIT)
      ) dut
      (.clk_i(clk_i)
     , .reset_i(reset_i)
     , .arb_bus(bus.slave)
`ifdef BP_DCACHE_ARB_PERF_EN
     , .pipe_grants_o(pipe_grants)
     , .ptw_grants_o(ptw_grants)
     , .conflict_cycles_o(conflict_cycles)
`endif
      );

    // Reference model: list of in-flight ops, each with its age (1 = tag stage, 2 = data stage).
    typedef struct {
        int age;
        bit own_ptw;
    } op_t;

    op_t         ops[$];
    int          m_starve;
    logic [31:0] m_pipe_cnt, m_ptw_cnt, m_conf_cnt;
    bit          eg_pipe, eg_ptw;

    int n_cmp = 0;
    int n_err = 0;

    logic obs_pipe_grant, obs_ptw_grant, obs_dcache_v, obs_ptag_v;
    logic obs_pipe_early, obs_ptw_early, obs_busy;
    logic [PTAGW-1:0] obs_ptag;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit pv, input bit tv, input bit lock, input bit rdy,
                         input bit fl, input bit early, input bit pptv, input bit tptv);
        logic [95:0] r;
        bus.pipe_v         = pv;
        bus.ptw_v          = tv;
        bus.ptw_lock       = lock;
        bus.dcache_ready   = rdy;
        bus.flush          = fl;
        bus.dcache_early_v = early;
        bus.pipe_ptag_v    = pptv;
        bus.ptw_ptag_v     = tptv;
        r = {$urandom(), $urandom(), $urandom()};
        bus.pipe_pkt = r[PKTW-1:0];
        r = {$urandom(), $urandom(), $urandom()};
        bus.ptw_pkt  = r[PKTW-1:0];
        r = {$urandom(), $urandom(), $urandom()};
        bus.pipe_ptag = r[PTAGW-1:0];
        bus.ptw_ptag  = r[PTAGW+31:32];
    endtask

    task automatic idle();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    // Compare all outputs against the model, then advance both across one clock edge.
    task automatic step();
        bit have1, have2, own1, own2;
        logic [PTAGW-1:0] e_ptag;
        bit e_ptag_v;
        op_t nq[$];
        #1;
        eg_pipe = 0;
        eg_ptw  = 0;
        if (bus.dcache_ready) begin
            if (bus.ptw_lock)                                      eg_ptw  = bus.ptw_v;
            else if (m_starve == LIMIT && bus.pipe_v && !bus.flush) eg_pipe = 1;
            else if (bus.ptw_v)                                     eg_ptw  = 1;
            else                                                    eg_pipe = bus.pipe_v && !bus.flush;
        end
        have1 = 0; have2 = 0; own1 = 0; own2 = 0;
        foreach (ops[i]) begin
            if (ops[i].age == 1) begin have1 = 1; own1 = ops[i].own_ptw; end
            if (ops[i].age == 2) begin have2 = 1; own2 = ops[i].own_ptw; end
        end
        e_ptag   = have1 ? (own1 ? bus.ptw_ptag : bus.pipe_ptag) : '0;
        e_ptag_v = have1 && (own1 ? bus.ptw_ptag_v : (bus.pipe_ptag_v && !bus.flush));

        obs_pipe_grant = bus.pipe_grant;
        obs_ptw_grant  = bus.ptw_grant;
        obs_dcache_v   = bus.dcache_v;
        obs_ptag       = bus.dcache_ptag;
        obs_ptag_v     = bus.dcache_ptag_v;
        obs_pipe_early = bus.pipe_early_v;
        obs_ptw_early  = bus.ptw_early_v;
        obs_busy       = bus.busy;

        check("pipe_grant", 128'(bus.pipe_grant), 128'(eg_pipe));
        check("ptw_grant", 128'(bus.ptw_grant), 128'(eg_ptw));
        check("dcache_v", 128'(bus.dcache_v), 128'(eg_pipe | eg_ptw));
        check("dcache_pkt", 128'(bus.dcache_pkt), 128'(eg_ptw ? bus.ptw_pkt : bus.pipe_pkt));
        check("dcache_ptag", 128'(bus.dcache_ptag), 128'(e_ptag));
        check("dcache_ptag_v", 128'(bus.dcache_ptag_v), 128'(e_ptag_v));
        check("pipe_early_v", 128'(bus.pipe_early_v), 128'(bus.dcache_early_v && have2 && !own2));
        check("ptw_early_v", 128'(bus.ptw_early_v), 128'(bus.dcache_early_v && have2 && own2));
        check("busy", 128'(bus.busy), 128'(have1 || have2));
`ifdef BP_DCACHE_ARB_PERF_EN
        check("pipe_grants", 128'(pipe_grants), 128'(m_pipe_cnt));
        check("ptw_grants", 128'(ptw_grants), 128'(m_ptw_cnt));
        check("conflict_cycles", 128'(conflict_cycles), 128'(m_conf_cnt));
`endif

        @(posedge clk_i);
        if (reset_i) begin
            ops.delete();
            m_starve   = 0;
            m_pipe_cnt = '0;
            m_ptw_cnt  = '0;
            m_conf_cnt = '0;
        end else begin
            foreach (ops[i]) begin
                op_t o;
                o = ops[i];
                o.age++;
                if (o.age <= 2 && !(bus.flush && !o.own_ptw)) nq.push_back(o);
            end
            if (eg_pipe || eg_ptw) begin
                op_t o;
                o.age = 1;
                o.own_ptw = eg_ptw;
                nq.push_back(o);
            end
            ops = nq;
            if (eg_pipe) m_starve = 0;
            else if (bus.pipe_v && !bus.ptw_lock && bus.dcache_ready && eg_ptw)
                m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
            m_pipe_cnt += 32'(eg_pipe);
            m_ptw_cnt  += 32'(eg_ptw);
            m_conf_cnt += 32'(bus.pipe_v && bus.ptw_v && bus.dcache_ready);
        end
        @(negedge clk_i);
    endtask

    initial begin
        reset_i = 1'b1;
        idle();
        ops.delete();
        m_starve = 0; m_pipe_cnt = '0; m_ptw_cnt = '0; m_conf_cnt = '0;
        @(negedge clk_i);
        step();
        step();
        reset_i = 1'b0;
        step();
        check("rst_busy", 128'(obs_busy), 128'(0));
        check("rst_ptag", 128'(obs_ptag), 128'(0));

        // Starvation: eight ptw wins, then one forced pipe grant, then ptw again.
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 1, 0, 0, 0, 0);
            step();
            if (i < LIMIT)       check("starve_ptw", 128'(obs_ptw_grant), 128'(1));
            else if (i == LIMIT) check("starve_pipe", 128'(obs_pipe_grant), 128'(1));
            else                 check("starve_clear", 128'(obs_ptw_grant), 128'(1));
        end
        repeat (3) begin idle(); step(); end

        // Pipe op through mem1/mem2.
        drive(1, 0, 0, 1, 0, 0, 0, 0);
        step();
        check("pipe_alone", 128'(obs_pipe_grant), 128'(1));
        drive(0, 0, 0, 1, 0, 0, 1, 0);
        bus.pipe_ptag = 28'h123;
        step();
        check("ptag_mem1", 128'(obs_ptag), 128'(28'h123));
        check("ptag_v_mem1", 128'(obs_ptag_v), 128'(1));
        drive(0, 0, 0, 1, 0, 1, 0, 0);
        step();
        check("pipe_early", 128'(obs_pipe_early), 128'(1));
        check("ptw_early_off", 128'(obs_ptw_early), 128'(0));

        // Build some starvation, then lock: pipe is blocked and the count must hold.
        for (int i = 0; i < 3; i++) begin drive(1, 1, 0, 1, 0, 0, 0, 0); step(); end
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 1, 1, 0, 0, 0, 0);
            step();
            check("lock_no_v", 128'(obs_dcache_v), 128'(0));
        end
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, 1, 0, 0, 0, 0);
            step();
            if (i == 5) check("lock_held", 128'(obs_pipe_grant), 128'(1));
        end
        repeat (3) begin idle(); step(); end

        // Flush kills the pipe op in mem1; a ptw op granted alongside survives.
        drive(1, 0, 0, 1, 0, 0, 0, 0);
        step();
        drive(0, 1, 0, 1, 1, 0, 1, 0);
        step();
        check("flush_ptag_v", 128'(obs_ptag_v), 128'(0));
        check("flush_ptw_grant", 128'(obs_ptw_grant), 128'(1));
        drive(0, 0, 0, 1, 0, 1, 0, 1);
        step();
        check("flush_no_early", 128'(obs_pipe_early), 128'(0));
        drive(0, 0, 0, 1, 0, 1, 0, 0);
        step();
        check("flush_ptw_early", 128'(obs_ptw_early), 128'(1));

        // Not ready: no grants.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0);
            step();
            check("not_ready", 128'(obs_dcache_v), 128'(0));
        end

        // Reset with mem1 and mem2 occupied.
        drive(0, 1, 0, 1, 0, 0, 0, 0); step();
        drive(1, 0, 0, 1, 0, 0, 0, 0); step();
        reset_i = 1'b1;
        drive(0, 0, 0, 1, 0, 1, 1, 1);
        step();
        reset_i = 1'b0;
        drive(0, 0, 0, 1, 0, 1, 1, 1);
        step();
        check("rst_mid_busy", 128'(obs_busy), 128'(0));
        check("rst_mid_ptag_v", 128'(obs_ptag_v), 128'(0));
        check("rst_mid_early", 128'({obs_pipe_early, obs_ptw_early}), 128'(0));

        // Random traffic, with the occasional reset.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 80,
                  $urandom_range(0, 99) < 10, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            reset_i = ($urandom_range(0, 99) < 2);
            step();
        end
        reset_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
